// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with any depth >= 2, exact level, almost thresholds and sticky error flags.
// Latency: a write is readable from the next edge; a standard read returns data one cycle after it is accepted.
// Backpressure: writes are refused while full and reads while empty; each refusal sets a sticky flag.
// Optional macro SYNC_FIFO_FWFT_EN: first-word-fall-through, so the head entry is shown while not empty.
module sync_fifo_lvl #(
  parameter int BITS     = 32,
  parameter int SIZE     = 16,
  parameter int AF_LEVEL = SIZE - 2,
  parameter int AE_LEVEL = 2,
  localparam int LW      = $clog2(SIZE + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p_write_en,
  input  logic [BITS-1:0] p_write_data,
  output logic            p_write_full,
  output logic            p_write_almost_full,
  input  logic            p_read_en,
  output logic [BITS-1:0] p_read_data,
  output logic            p_read_empty,
  output logic            p_read_almost_empty,
  output logic [LW-1:0]   p_level,
  output logic            p_overflow,
  output logic            p_underflow,
  input  logic            p_err_clr
);

  // Pointer width covers 0..SIZE-1; pointers wrap by compare, so SIZE need not be a power of two.
  localparam int PW = (SIZE > 2) ? $clog2(SIZE) : 1;

  // Parameter sanity is checked while the design is elaborated.
  if (SIZE < 2) begin : g_bad_size
    $fatal(1, "sync_fifo_lvl: SIZE must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > SIZE) begin : g_bad_af
    $fatal(1, "sync_fifo_lvl: AF_LEVEL must be within 1..SIZE");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > SIZE - 1) begin : g_bad_ae
    $fatal(1, "sync_fifo_lvl: AE_LEVEL must be within 0..SIZE-1");
  end

  logic [BITS-1:0] mem_q [SIZE];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            full_q, full_d;
  logic            afull_q, afull_d;
  logic            empty_q, empty_d;
  logic            aempty_q, aempty_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [BITS-1:0] rdat_q, rdat_d;
  logic            wr_acc;
  logic            rd_acc;

  // Next-state: acceptance from the registered flags, pointer wrap, level and flags from the next level.
  always_comb begin
    wr_acc   = p_write_en && !full_q;
    rd_acc   = p_read_en && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    rdat_d   = rdat_q;

    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == PW'(SIZE - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == PW'(SIZE - 1)) ? '0 : rd_ptr_q + PW'(1);
      // Holds the popped word: the read result in standard mode, the "last popped" value in FWFT mode.
      rdat_d   = mem_q[rd_ptr_q];
    end

    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    full_d   = (level_d == LW'(SIZE));
    afull_d  = (level_d >= LW'(AF_LEVEL));
    empty_d  = (level_d == '0);
    aempty_d = (level_d <= LW'(AE_LEVEL));

    // A new error in the same cycle as a clear keeps the flag set.
    ovf_d = (ovf_q && !p_err_clr) || (p_write_en && full_q);
    unf_d = (unf_q && !p_err_clr) || (p_read_en && empty_q);
  end

  // Control state register; reset discards all entries in one cycle and ignores requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rdat_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rdat_q   <= rdat_d;
    end
  end

  // Storage array, not cleared by reset; writes are blocked while reset is high.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q] <= p_write_data;
    end
  end

  assign p_write_full        = full_q;
  assign p_write_almost_full = afull_q;
  assign p_read_empty        = empty_q;
  assign p_read_almost_empty = aempty_q;
  assign p_level             = level_q;
  assign p_overflow          = ovf_q;
  assign p_underflow         = unf_q;

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry falls through while not empty; otherwise the last popped word (0 after reset).
  assign p_read_data = empty_q ? rdat_q : mem_q[rd_ptr_q];
`else
  assign p_read_data = rdat_q;
`endif

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed bench for sync_fifo_lvl: reset, fill/overflow, wrap on SIZE=5, simultaneous traffic,
// underflow with clear, and mid-operation reset. Inputs change 1 time unit after the rising edge,
// outputs are sampled at that same point, well clear of the next edge.
module tb_sync_fifo_lvl;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_clr;

  logic        we, re;
  logic [31:0] wdat, rdat;
  logic        full, afull, empty, aempty, ovf, unf;
  logic [4:0]  level;

  logic        w5_en, r5_en;
  logic [31:0] w5_dat, r5_dat;
  logic        f5_full, f5_afull, f5_empty, f5_aempty, f5_ovf, f5_unf;
  logic [2:0]  f5_level;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_fifo_lvl #(.BITS(32), .SIZE(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst),
    .p_write_en(we), .p_write_data(wdat),
    .p_write_full(full), .p_write_almost_full(afull),
    .p_read_en(re), .p_read_data(rdat),
    .p_read_empty(empty), .p_read_almost_empty(aempty),
    .p_level(level), .p_overflow(ovf), .p_underflow(unf),
    .p_err_clr(err_clr)
  );

  sync_fifo_lvl #(.BITS(32), .SIZE(5)) dut5 (
    .clk(clk), .rst(rst),
    .p_write_en(w5_en), .p_write_data(w5_dat),
    .p_write_full(f5_full), .p_write_almost_full(f5_afull),
    .p_read_en(r5_en), .p_read_data(r5_dat),
    .p_read_empty(f5_empty), .p_read_almost_empty(f5_aempty),
    .p_level(f5_level), .p_overflow(f5_ovf), .p_underflow(f5_unf),
    .p_err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    we   = 1'b1;
    wdat = d;
    step();
    we   = 1'b0;
  endtask

  // Returns the word removed by one accepted read in either read mode.
  task automatic pop(output logic [31:0] d);
`ifdef SYNC_FIFO_FWFT_EN
    d  = rdat;
    re = 1'b1;
    step();
    re = 1'b0;
`else
    re = 1'b1;
    step();
    re = 1'b0;
    d  = rdat;
`endif
  endtask

  initial begin
    logic [31:0] d;
    int wn, rn, cyc;
    logic wacc, racc;

    rst = 1'b1; err_clr = 1'b0;
    we = 1'b1; re = 1'b1; wdat = 32'hDEAD_BEEF;
    w5_en = 1'b1; r5_en = 1'b1; w5_dat = 32'h1234;

    // 1. Reset with both requests held high.
    #1;
    repeat (3) step();
    chk("rst_empty", empty, 1);
    chk("rst_aempty", aempty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", afull, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    chk("rst_rdata", rdat, 0);
    chk("rst5_level", f5_level, 0);
    we = 1'b0; re = 1'b0; w5_en = 1'b0; r5_en = 1'b0;
    rst = 1'b0;
    step();

    // 2. Fill to full, overflow, drain in order.
    for (int i = 0; i < 16; i++) begin
      push(i);
      chk("fill_level", level, i + 1);
      chk("fill_afull", afull, (i + 1 >= 14));
      chk("fill_full", full, (i + 1 == 16));
      chk("fill_aempty", aempty, (i + 1 <= 2));
    end
    chk("fill_empty", empty, 0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_head_full", rdat, 0);
`endif
    push(32'h99);
    chk("ovf_set", ovf, 1);
    chk("ovf_level", level, 16);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    for (int i = 0; i < 16; i++) begin
      pop(d);
      chk("drain_data", d, i);
      chk("drain_level", level, 15 - i);
    end
    chk("drain_empty", empty, 1);
    chk("drain_unf", unf, 0);

    // 3. Wrap on a SIZE=5 FIFO with a random write/read mix.
    wn = 0; rn = 0; cyc = 0;
    while (rn < 23 && cyc < 2000) begin
      w5_en  = (wn < 23) && !f5_full && ($urandom_range(0, 1) == 1);
      w5_dat = wn;
      r5_en  = !f5_empty && ($urandom_range(0, 1) == 1);
      wacc   = w5_en;
      racc   = r5_en;
`ifdef SYNC_FIFO_FWFT_EN
      if (racc) chk("wrap_data", r5_dat, rn);
`endif
      step();
      if (wacc) wn++;
      if (racc) begin
`ifndef SYNC_FIFO_FWFT_EN
        chk("wrap_data", r5_dat, rn);
`endif
        rn++;
      end
      if (f5_level > 5) chk("wrap_level_max", f5_level, 5);
      cyc++;
    end
    w5_en = 1'b0; r5_en = 1'b0;
    chk("wrap_count", rn, 23);
    chk("wrap_ovf", f5_ovf, 0);
    chk("wrap_unf", f5_unf, 0);
    chk("wrap_empty", f5_empty, 1);

    // 4. Simultaneous write and read at level 8.
    for (int i = 0; i < 8; i++) push(100 + i);
    chk("sim_level0", level, 8);
    for (int k = 0; k < 10; k++) begin
      we = 1'b1; re = 1'b1; wdat = 108 + k;
`ifdef SYNC_FIFO_FWFT_EN
      chk("sim_data", rdat, 100 + k);
`endif
      step();
`ifndef SYNC_FIFO_FWFT_EN
      chk("sim_data", rdat, 100 + k);
`endif
      chk("sim_level", level, 8);
      chk("sim_afull", afull, 0);
      chk("sim_aempty", aempty, 0);
    end
    we = 1'b0; re = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pop(d);
      chk("sim_tail", d, 110 + i);
    end
    chk("sim_empty", empty, 1);

    // 5. Underflow and clear.
    re = 1'b1;
    step();
    re = 1'b0;
    chk("unf_set", unf, 1);
    chk("unf_rdata", rdat, 117);
    chk("unf_level", level, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("unf_clr", unf, 0);

    // 6. Reset in mid-operation, then a fresh word.
    for (int i = 0; i < 7; i++) push(200 + i);
    chk("mid_level7", level, 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_level", level, 0);
    chk("mid_empty", empty, 1);
    chk("mid_rdata", rdat, 0);
    push(32'hA5A5_A5A5);
    chk("mid_level1", level, 1);
    chk("mid_nempty", empty, 0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_head", rdat, 32'hA5A5_A5A5);
`endif
    pop(d);
    chk("mid_data", d, 32'hA5A5_A5A5);
    chk("mid_empty2", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_lvl.md
# sync_fifo_lvl

Single-clock, parametrised FIFO for intra-domain buffering next to `async_fifo`. It keeps the same `p_write_*`/`p_read_*` port family and adds:
- arbitrary (non-power-of-two) depth;
- exact occupancy level;
- programmable almost-full/almost-empty thresholds;
- sticky overflow/underflow error flags;
- an optional first-word-fall-through read mode.

## Interface
Parameters:
- BITS, 32, width of each entry.
- SIZE, 16, number of entries; any value >= 2, power of two not required.
- AF_LEVEL, SIZE-2, almost-full threshold; legal range 1..SIZE.
- AE_LEVEL, 2, almost-empty threshold; legal range 0..SIZE-1.

Ports (LW = $clog2(SIZE+1)):
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- p_write_en  in  1  write request.
- p_write_data  in  BITS  write data.
- p_write_full  out  1  level == SIZE.
- p_write_almost_full  out  1  level >= AF_LEVEL.
- p_read_en  in  1  read request.
- p_read_data  out  BITS  read data.
- p_read_empty  out  1  level == 0.
- p_read_almost_empty  out  1  level <= AE_LEVEL.
- p_level  out  LW  exact occupancy, 0..SIZE.
- p_overflow  out  1  sticky: write attempted while full.
- p_underflow  out  1  sticky: read attempted while empty.
- p_err_clr  in  1  clears both sticky flags.

## Operation
- Write accepted iff p_write_en && !p_write_full. Accepted write stores data at wr_ptr and advances wr_ptr.
- Read accepted iff p_read_en && !p_read_empty. Accepted read advances rd_ptr.
- Pointers are 0..SIZE-1 and wrap SIZE-1 -> 0 by explicit compare, not bit truncation.
- Level update per cycle:
  - write only: +1;
  - read only: -1;
  - both or neither: unchanged.
- All flags are registered and derived from the next level, so they change on the same edge as p_level.
- Rejected write sets p_overflow; memory, pointers and level are untouched.
- Rejected read sets p_underflow; p_read_data is untouched.
- p_err_clr clears both flags. If a new error occurs in the same cycle as p_err_clr, set wins.
- Full flag is registered: a write while full is rejected even if a read is accepted in the same cycle.
- Illegal SIZE, AF_LEVEL or AE_LEVEL -> $fatal at elaboration.

## Timing
Reset (rst=1 at an edge) sets:
- pointers 0, p_level 0;
- p_read_empty 1, p_read_almost_empty 1;
- p_write_full 0, p_write_almost_full 0;
- p_overflow 0, p_underflow 0;
- p_read_data 0.

During reset:
- p_write_en and p_read_en are ignored and raise no error flags.
- Memory contents are not cleared.
- Reset asserted mid-operation discards all stored entries within that one cycle.

Write latency: a write accepted at edge N gives p_level+1 and p_read_empty=0 after edge N. The entry is readable from the next edge.

Read latency:
- Standard mode: a read accepted at edge N puts the entry on p_read_data after edge N (one cycle).
- p_read_data holds its value until the next accepted read.

Throughput: one write and one read per cycle, sustained, at any level 1..SIZE-1.

## Configuration
Macro `SYNC_FIFO_FWFT_EN` selects the read mode.

Defined (first-word-fall-through):
- p_read_data shows the head entry whenever p_read_empty=0.
- p_read_en acknowledges and pops that entry; the next entry appears after the same edge.
- Value while empty: last popped data, or 0 after reset.

Undefined: standard registered read as described in Timing.

## Test plan
1. Reset: hold rst=1 for 3 cycles while p_write_en=p_read_en=1. Required: empty=1, almost_empty=1, full=0, level=0, overflow=underflow=0, read_data=0.
2. Fill, SIZE=16, AF_LEVEL=14:
   - Write 0..15 on consecutive cycles: level 1..16; almost_full rises after write 14; full after write 16.
   - 17th write: overflow=1, level stays 16.
   - Read 16: data 0..15 in order; empty=1 after the last read.
3. Wrap, SIZE=5: 23 words with a random write/read mix. Required: output order exactly 0..22, level never > 5, no error flags.
4. Simultaneous: at level 8, write and read on the same cycle for 10 cycles. Required: level stays 8, almost flags constant, order preserved.
5. Underflow: read while empty. Required: underflow=1, read_data unchanged. Pulse p_err_clr: underflow=0.
6. Mid-op reset: at level 7, rst=1 for 1 cycle. Required: level=0, empty=1. Then write 0xA5A5A5A5 and read it: returns 0xA5A5A5A5, not stale data.

Run scenarios 2 and 6 with `SYNC_FIFO_FWFT_EN` as well:
- head data is visible with empty=0 and no p_read_en;
- no cycle of read latency.
